rf_burst_gate: RTL

Lock-qualified RF burst gate that sits directly downstream of the RF PLL and runs on its 184.523809 MHz output clock. It synchronises and debounces the PLL `locked` flag, and releases triggered bursts only while the clock is proven stable. Each burst is a programmable train of gate pulses driving the RF output stage. Loss of lock mid-burst aborts the train cleanly and is recorded in a sticky flag.

---
 rtl/rf_burst_gate.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rf_burst_gate.sv
// rf_burst_gate: lock-qualified RF burst gate in the PLL output clock domain.
// Synchronises and debounces the PLL locked flag and emits programmable
// trains of gate pulses only while lock is qualified. Loss of lock aborts
// a running train and sets a sticky flag.
module rf_burst_gate #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CNT_W              = 16,
  parameter int NP_W               = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             trig,
  input  logic [CNT_W-1:0] on_len,
  input  logic [CNT_W-1:0] off_len,
  input  logic [NP_W-1:0]  n_pulses,
  input  logic             clr_err,
  output logic             rf_gate,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic             cfg_err,
  output logic             lock_ok,
  output logic             lock_lost
);

  localparam int LCW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_STABLE_CYCLES);
  localparam logic [LCW-1:0]   LCNT_ONE = LCW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [NP_W-1:0]  NP_ONE   = NP_W'(1);

  typedef enum logic [1:0] {WAIT_LOCK, READY, ON, OFF} state_t;

  logic           lock_meta;
  logic           lock_s;
  logic [LCW-1:0] lock_cnt;

  state_t           state, state_nx;
  logic [CNT_W-1:0] on_lat, off_lat;
  logic [CNT_W-1:0] on_cnt, on_cnt_nx;
  logic [CNT_W-1:0] off_cnt, off_cnt_nx;
  logic [NP_W-1:0]  pcnt, pcnt_nx;
  logic             cfg_load;
  logic             gate_nx, done_nx, abort_nx, cfg_err_nx;

  // Two-flop synchroniser for the asynchronous PLL locked flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Saturating stability counter; lock_ok rises on the edge the count reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      lock_ok  <= 1'b0;
    end else if (!lock_s) begin
      lock_cnt <= '0;
      lock_ok  <= 1'b0;
    end else if (lock_cnt != LOCK_MAX) begin
      lock_cnt <= lock_cnt + LCNT_ONE;
      lock_ok  <= (lock_cnt == (LOCK_MAX - LCNT_ONE));
    end
  end

  // Sticky loss-of-lock flag; a new loss beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_lost <= 1'b0;
    end else if (lock_ok && !lock_s) begin
      lock_lost <= 1'b1;
    end else if (clr_err) begin
      lock_lost <= 1'b0;
    end
  end

  // Next-state and next-output logic; lock loss overrides any burst activity.
  always_comb begin
    state_nx   = state;
    on_cnt_nx  = on_cnt;
    off_cnt_nx = off_cnt;
    pcnt_nx    = pcnt;
    cfg_load   = 1'b0;
    done_nx    = 1'b0;
    abort_nx   = 1'b0;
    cfg_err_nx = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_ok) state_nx = READY;
      end
      READY: begin
        if (!lock_ok) begin
          state_nx = WAIT_LOCK;
        end else if (trig) begin
          if ((on_len != '0) && (n_pulses != '0)) begin
            cfg_load  = 1'b1;
            on_cnt_nx = on_len - CNT_ONE;
            pcnt_nx   = n_pulses - NP_ONE;
            state_nx  = ON;
          end else begin
            cfg_err_nx = 1'b1;
          end
        end
      end
      ON: begin
        if (!lock_ok) begin
          abort_nx = 1'b1;
          state_nx = WAIT_LOCK;
        end else if (on_cnt != '0) begin
          on_cnt_nx = on_cnt - CNT_ONE;
        end else if (pcnt == '0) begin
          done_nx  = 1'b1;
          state_nx = READY;
        end else begin
          pcnt_nx = pcnt - NP_ONE;
          if (off_lat == '0) begin
            // Zero off length: pulses merge into one continuous gate.
            on_cnt_nx = on_lat - CNT_ONE;
          end else begin
            off_cnt_nx = off_lat - CNT_ONE;
            state_nx   = OFF;
          end
        end
      end
      OFF: begin
        if (!lock_ok) begin
          abort_nx = 1'b1;
          state_nx = WAIT_LOCK;
        end else if (off_cnt != '0) begin
          off_cnt_nx = off_cnt - CNT_ONE;
        end else begin
          on_cnt_nx = on_lat - CNT_ONE;
          state_nx  = ON;
        end
      end
      default: state_nx = WAIT_LOCK;
    endcase
    gate_nx = (state_nx == ON);
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_LOCK;
      rf_gate <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nx;
      rf_gate <= gate_nx;
      done    <= done_nx;
      abort   <= abort_nx;
      cfg_err <= cfg_err_nx;
    end
  end

  // Latched burst configuration and down-counters; only read after a load.
  always_ff @(posedge clk) begin
    if (cfg_load) begin
      on_lat  <= on_len;
      off_lat <= off_len;
    end
    on_cnt  <= on_cnt_nx;
    off_cnt <= off_cnt_nx;
    pcnt    <= pcnt_nx;
  end

  assign busy = (state == ON) || (state == OFF);

endmodule
